hilo_unit: RTL and testbench

// - Issue/commit stage wrapped around multiplier_pipelined (32x32 unsigned -> 64, fixed 2-cycle latency, no reset).
// - Accepts MULT/MULTU/MADD/MSUB/MTHI/MTLO ops from the execute stage.
// - Drives operand magnitudes to the multiplier, consumes its 64-bit product, applies sign/accumulate and commits HI/LO.
// - Keeps at most one multiply in flight; stalls issue via op_ready.

---
 rtl/hilo_pkg.sv | 16 +
 rtl/hilo_signfix.sv | 16 +
 rtl/multiplier_pipelined.sv | 13 +
 rtl/hilo_unit.sv | 87 ++++++++
 tb/tb_hilo_unit.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: opcodes, FSM states and shared helpers for the HI/LO multiply unit
package hilo_pkg;
  localparam int MUL_LATENCY_DEF = 2;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;
  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_e;
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/hilo_signfix.sv
// hilo_signfix: re-applies the product sign and folds it into {hi,lo} for MULT/MADD/MSUB
module hilo_signfix
  import hilo_pkg::*;
(
  input  logic        i_neg,
  input  op_e         i_op,
  input  logic [63:0] i_acc,
  input  logic [63:0] i_prod,
  output logic [63:0] o_acc
);
  logic [63:0] w_p;
  always_comb begin
    w_p = i_neg ? -i_prod : i_prod;
    o_acc = (i_op == OP_MADD) ? i_acc + w_p : (i_op == OP_MSUB) ? i_acc - w_p : w_p;
  end
endmodule

// File: rtl/multiplier_pipelined.sv
// multiplier_pipelined: 32x32 unsigned multiply, two register stages, no reset
module multiplier_pipelined (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] r
);
  logic [63:0] r_s1;
  always_ff @(posedge clk) begin
    r_s1 <= {32'b0, a} * {32'b0, b};
    r <= r_s1;
  end
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: issue/commit stage around an external fixed-latency multiplier, owns HI/LO
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        op_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_r,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);
  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_neg;
  op_e           r_op;
  logic [31:0]   r_hi, r_lo, r_mul_a, r_mul_b;
  op_e           w_op;
  logic          w_accept, w_is_mul, w_signed;
  logic [63:0]   w_acc_nxt;
  assign w_op     = op_e'(op_code);
  assign w_accept = op_valid && r_state == IDLE;
  assign w_is_mul = !op_code[2];
  assign w_signed = w_op != OP_MULTU;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE) ? ((w_accept && w_is_mul) ? WAIT : IDLE) :
                  (r_state == WAIT) ? ((r_cnt == CW'(MUL_LATENCY - 1)) ? COMMIT : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
    end
  end
  // multiplier sees magnitudes only; the sign travels alongside in r_neg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_neg <= 1'b0;
      r_op <= OP_MULT;
    end else if (w_accept && w_is_mul) begin
      r_mul_a <= mag(rs_val, w_signed);
      r_mul_b <= mag(rt_val, w_signed);
      r_neg <= w_signed && (rs_val[31] ^ rt_val[31]);
      r_op <= w_op;
    end
  end
  hilo_signfix u_signfix (
    .i_neg (r_neg),
    .i_op  (r_op),
    .i_acc ({r_hi, r_lo}),
    .i_prod(mul_r),
    .o_acc (w_acc_nxt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == COMMIT) begin
      {r_hi, r_lo} <= w_acc_nxt;
    end else if (w_accept && w_op == OP_MTHI) begin
      r_hi <= rs_val;
    end else if (w_accept && w_op == OP_MTLO) begin
      r_lo <= rs_val;
    end
  end
  assign op_ready = r_state == IDLE;
  assign busy     = !op_ready;
  assign mul_a    = r_mul_a;
  assign mul_b    = r_mul_b;
  assign hi       = r_hi;
  assign lo       = r_lo;
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed and random checks of hilo_unit against a 64-bit arithmetic model
module tb_hilo_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        op_ready, busy;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic [63:0] mul_r;
  int          npass = 0, ntot = 0;
  logic [63:0] ref_acc = '0;
  logic [31:0] last_a, last_b;
  int          cyc;

  hilo_unit dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .mul_a(mul_a),
    .mul_b(mul_b), .mul_r(mul_r), .hi(hi), .lo(lo), .busy(busy)
  );
  multiplier_pipelined u_mul (.clk(clk), .a(mul_a), .b(mul_b), .r(mul_r));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] c, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] s, u;
    s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    u = {32'b0, a} * {32'b0, b};
    case (c)
      3'd0: return s;
      3'd1: return u;
      3'd2: return acc + s;
      3'd3: return acc - s;
      3'd4: return {a, acc[31:0]};
      3'd5: return {acc[63:32], a};
      default: return acc;
    endcase
  endfunction

  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_code = c; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    last_a = mul_a; last_b = mul_b;
    ref_acc = model(c, a, b, ref_acc);
    cyc = 0;
    while (!op_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [4];
    sp[0] = 32'h0; sp[1] = 32'hFFFFFFFF; sp[2] = 32'h80000000; sp[3] = 32'h7FFFFFFF;
    return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
  endfunction

  initial begin
    logic [2:0]  rc;
    logic [31:0] ra, rb;
    repeat (2) @(posedge clk); #1;
    chk("reset_hilo", {hi, lo}, 64'h0);
    chk("reset_mul_ops", {mul_a, mul_b}, 64'h0);
    chk("reset_ready_busy", {62'h0, op_ready, busy}, 64'h2);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 32'd3, 32'hFFFFFFFC);
    chk("mult_occupancy", 64'(cyc), 64'd3);
    chk("mult_mag", {last_a, last_b}, {32'd3, 32'd4});
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF4);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mult_mag_m1", {last_a, last_b}, {32'd1, 32'd1});
    chk("mult_m1_m1", {hi, lo}, 64'h1);
    issue(3'd4, 32'h7FFFFFFF, 32'h0);
    chk("mthi_no_busy", 64'(cyc), 64'd0);
    issue(3'd5, 32'hFFFFFFFF, 32'h0);
    issue(3'd2, 32'd1, 32'd1);
    chk("madd_carry", {hi, lo}, 64'h80000000_00000000);
    issue(3'd4, 32'h0, 32'h0);
    issue(3'd5, 32'h0, 32'h0);
    issue(3'd3, 32'd1, 32'd1);
    chk("msub_wrap", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
    issue(3'd0, 32'h80000000, 32'd2);
    chk("mult_minint_mag", 64'(last_a), 64'h80000000);
    chk("mult_minint", {hi, lo}, 64'hFFFFFFFF_00000000);
    issue(3'd6, 32'h1234, 32'h5678);
    chk("reserved_noop", {hi, lo}, 64'hFFFFFFFF_00000000);

    op_valid = 1'b1; op_code = 3'd0; rs_val = 32'd5; rt_val = 32'd7;
    @(posedge clk); #1;
    op_code = 3'd2; rs_val = 32'd2; rt_val = 32'd3;
    repeat (2) @(posedge clk); #1;
    chk("held_not_taken", {31'h0, op_ready, mul_a}, {31'h0, 1'b0, 32'd5});
    chk("held_hilo_hold", {hi, lo}, 64'hFFFFFFFF_00000000);
    @(posedge clk); #1;
    chk("held_first_commit", {hi, lo}, 64'd35);
    chk("held_ready_after", {63'h0, op_ready}, 64'h1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("held_accepted", {31'h0, op_ready, mul_a}, {31'h0, 1'b0, 32'd2});
    repeat (6) @(posedge clk); #1;
    chk("held_one_commit", {hi, lo}, 64'd41);
    ref_acc = 64'd41;

    op_valid = 1'b1; op_code = 3'd5; rs_val = 32'hAAAA;
    @(posedge clk); #1;
    chk("mtlo_b2b_1", {31'h0, op_ready, lo}, {31'h0, 1'b1, 32'hAAAA});
    rs_val = 32'h5555;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("mtlo_b2b_2", {hi, lo}, 64'h5555);

    issue(3'd4, 32'h1234, 32'h0);
    op_valid = 1'b1; op_code = 3'd0; rs_val = 32'd9; rt_val = 32'd9;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_hilo", {hi, lo}, 64'h0);
    chk("midrst_ready", {62'h0, op_ready, busy}, 64'h2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("midrst_no_commit", {hi, lo}, 64'h0);
    chk("midrst_ready_after", {63'h0, op_ready}, 64'h1);
    ref_acc = '0;

    for (int i = 0; i < 10000; i++) begin
      rc = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      issue(rc, ra, rb);
      chk("rand_occupancy", 64'(cyc), (rc < 3'd4) ? 64'd3 : 64'd0);
      chk("rand_hilo", {hi, lo}, ref_acc);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
